// File: rtl/serial_div_pkg.sv
// Shared types and constants for the serial divisibility arbiter.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package serial_div_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DIVISOR = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Residue width: enough bits to hold 0..divisor-1.
    function automatic int rem_width(input int divisor);
        return $clog2(divisor);
    endfunction

    // One MSB-first residue step: (2*rem + b) mod divisor, with rem < divisor.
    function automatic int mod_step(input int rem, input logic b, input int divisor);
        int v;
        v = 2 * rem + (b ? 1 : 0);
        return (v >= divisor) ? v - divisor : v;
    endfunction

endpackage

// File: rtl/serial_mod_core.sv
// Serial MSB-first mod-DIVISOR residue tracker, one bit per enabled clock.
// Latency: residue reflects bit_in one clock after en; clr zeroes it next clock.
// Backpressure: none; en gates absorption, clr has priority over en.
// Ports: clk, rst_n (sync, active-low), clr, en, bit_in -> rem[RW-1:0].
module serial_mod_core
    import serial_div_pkg::*;
#(
    parameter int DIVISOR = DEF_DIVISOR,
    parameter int RW      = rem_width(DIVISOR)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [RW-1:0] rem
);

    localparam logic [RW:0] L_DIV = (RW+1)'(DIVISOR);

    logic [RW-1:0] r_rem;
    logic [RW:0]   w_dbl;
    logic [RW-1:0] w_sub;
    logic [RW-1:0] w_nxt;

    // 2*rem+bit < 2*DIVISOR, so one conditional subtract suffices. The
    // subtracted result is below DIVISOR (< 2^RW), so only its low RW bits
    // matter and the high bit of the divisor drops out of the difference.
    assign w_dbl = {r_rem, bit_in};
    assign w_sub = w_dbl[RW-1:0] - L_DIV[RW-1:0];
    assign w_nxt = (w_dbl >= L_DIV) ? w_sub : w_dbl[RW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem <= '0;
        end else if (clr) begin
            r_rem <= '0;
        end else if (en) begin
            r_rem <= w_nxt;
        end
    end

    assign rem = r_rem;

endmodule

// File: rtl/serial_div_arbiter.sv
// Round-robin shares one serial mod-DIVISOR checker among NREQ word requesters.
// Latency: res_valid rises WIDTH+1 clocks after the accept edge; one word per WIDTH+2 clocks max.
// Backpressure: result held in DONE until res_ready; no grants while a word is in flight.
// Ports: clk, rst_n (sync, active-low); req_valid/req_data/req_ready per requester;
//        res_valid/res_ready handshake carrying res_id, res_div, res_rem.
module serial_div_arbiter
    import serial_div_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DIVISOR = DEF_DIVISOR,
    parameter int RW      = rem_width(DIVISOR),
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic                  res_div,
    output logic [RW-1:0]         res_rem
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [IDW-1:0]   r_id;
    logic             r_res_valid;
    logic [IDW-1:0]   r_res_id;
    logic             r_res_div;
    logic [RW-1:0]    r_res_rem;

    logic             w_found;
    logic [IDW-1:0]   w_gnt;
    logic [WIDTH-1:0] w_gnt_word;
    logic             w_accept;
    logic             w_shift_en;
    logic [RW-1:0]    w_rem;
    logic [RW-1:0]    w_fin_rem;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[IDW'((int'(r_rr_ptr) + k) % NREQ)]) begin
                w_found = 1'b1;
                w_gnt   = IDW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_gnt_word = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == w_gnt) begin
                w_gnt_word = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept   = (r_state == ST_IDLE) && w_found;
    assign req_ready  = w_accept ? (NREQ'(1) << w_gnt) : '0;
    assign w_shift_en = (r_state == ST_SHIFT);

    serial_mod_core #(
        .DIVISOR (DIVISOR),
        .RW      (RW)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_accept),
        .en     (w_shift_en),
        .bit_in (r_shift[WIDTH-1]),
        .rem    (w_rem)
    );

    // The core absorbs the last bit on the same edge that enters DONE, so the
    // result register captures the residue one step ahead of the core output.
    assign w_fin_rem = RW'(mod_step(int'(w_rem), r_shift[WIDTH-1], DIVISOR));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_id        <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_div   <= 1'b0;
            r_res_rem   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_shift  <= w_gnt_word;
                        r_cnt    <= CW'(WIDTH - 1);
                        r_id     <= w_gnt;
                        r_rr_ptr <= IDW'((int'(w_gnt) + 1) % NREQ);
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= r_shift << 1;
                    if (r_cnt == '0) begin
                        r_state     <= ST_DONE;
                        r_res_valid <= 1'b1;
                        r_res_id    <= r_id;
                        r_res_rem   <= w_fin_rem;
                        r_res_div   <= (w_fin_rem == '0);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_div   = r_res_div;
    assign res_rem   = r_res_rem;

endmodule

// File: tb/tb_serial_div_arbiter.sv
// Self-checking bench for serial_div_arbiter: directed table, corner sequences, random model.
// Latency: n/a.
// Backpressure: drives random res_ready stalls in the random phase.
module tb_serial_div_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int DIVISOR = 5;
    localparam int RW      = $clog2(DIVISOR);
    localparam int IDW     = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic                  res_div;
    logic [RW-1:0]         res_rem;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_div_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .DIVISOR (DIVISOR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_div   (res_div),
        .res_rem   (res_rem)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single-requester transaction; reports grant strobe, result and the
    // number of negedges from the accept edge until res_valid is seen.
    task automatic run_one(input int idx, input int data, output logic [NREQ-1:0] rdy,
                           output int id, output int dv, output int rm, output int lat);
        @(negedge clk);
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        req_data[idx*WIDTH +: WIDTH] = WIDTH'(data);
        res_ready      = 1'b1;
        #1 rdy = req_ready;
        @(negedge clk);
        req_valid = '0;
        lat = 1;
        #1;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            #1;
        end
        if (!res_valid) lat = -1;
        id = int'(res_id);
        dv = int'(res_div);
        rm = int'(res_rem);
    endtask

    typedef struct {
        int              idx;
        int              data;
        logic [NREQ-1:0] exp_rdy;
        int              exp_id;
        int              exp_div;
        int              exp_rem;
    } vec_t;

    vec_t vecs[8];

    // Random traffic checked cycle by cycle against a transaction-level model:
    // round-robin pick over pending requesters, result = word mod DIVISOR,
    // valid from WIDTH+1 cycles after accept until handshake.
    task automatic random_phase(input int ntx);
        int              issued;
        int              done;
        int              cyc;
        int              rr;
        int              since;
        int              g;
        int              exp_id;
        int              exp_rem;
        bit              in_flight;
        bit              exp_v;
        bit              pend[NREQ];
        logic [WIDTH-1:0] word[NREQ];
        logic [NREQ-1:0] exp_rdy;
        issued = 0; done = 0; cyc = 0; rr = 0; since = 0;
        exp_id = 0; exp_rem = 0; in_flight = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            word[i] = '0;
        end
        while (done < ntx && cyc < 60000) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && issued < ntx && $urandom_range(0, 3) == 0) begin
                    int r;
                    r = int'($urandom_range(0, 9));
                    pend[i] = 1'b1;
                    word[i] = (r == 0) ? '0 : (r == 1) ? '1 : WIDTH'($urandom);
                    issued++;
                end
                req_valid[i] = pend[i];
                req_data[i*WIDTH +: WIDTH] = word[i];
            end
            res_ready = ($urandom_range(0, 2) != 0);
            #1;
            g = -1;
            if (!in_flight) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && pend[(rr + k) % NREQ]) g = (rr + k) % NREQ;
                end
            end
            exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
            check("rand_req_ready", req_ready, exp_rdy);
            exp_v = in_flight && (since >= WIDTH);
            check("rand_res_valid", res_valid, exp_v);
            if (exp_v) begin
                check("rand_res_id", res_id, exp_id);
                check("rand_res_rem", res_rem, exp_rem);
                check("rand_res_div", res_div, (exp_rem == 0));
            end
            if (g >= 0) begin
                in_flight = 1'b1;
                since     = 0;
                exp_id    = g;
                exp_rem   = int'(word[g]) % DIVISOR;
                pend[g]   = 1'b0;
                rr        = (g + 1) % NREQ;
            end else if (in_flight) begin
                if (exp_v && res_ready) begin
                    in_flight = 1'b0;
                    done++;
                end else begin
                    since++;
                end
            end
            cyc++;
        end
        check("rand_all_completed", done, ntx);
        @(negedge clk);
        req_valid = '0;
        res_ready = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] rdy;
        int id, dv, rm, lat;
        int gcount, rcount, seen, w;
        int gidx[5];
        int gcyc[5];
        int dmod[NREQ];
        int exp_order[5];

        vecs[0] = '{0, 'h0A, 4'b0001, 0, 1, 0};
        vecs[1] = '{2, 'h07, 4'b0100, 2, 0, 2};
        vecs[2] = '{2, 'hFF, 4'b0100, 2, 1, 0};
        vecs[3] = '{2, 'h00, 4'b0100, 2, 1, 0};
        vecs[4] = '{2, 'hFE, 4'b0100, 2, 0, 4};
        vecs[5] = '{1, 'h0D, 4'b0010, 1, 0, 3};
        vecs[6] = '{3, 'h64, 4'b1000, 3, 1, 0};
        vecs[7] = '{1, 'h80, 4'b0010, 1, 0, 3};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_res_id", res_id, 0);
        check("reset_res_div", res_div, 0);
        check("reset_res_rem", res_rem, 0);
        rst_n = 1'b1;

        // Directed table.
        for (int v = 0; v < 8; v++) begin
            run_one(vecs[v].idx, vecs[v].data, rdy, id, dv, rm, lat);
            check("vec_req_ready", rdy, vecs[v].exp_rdy);
            check("vec_latency", lat, WIDTH + 1);
            check("vec_res_id", id, vecs[v].exp_id);
            check("vec_res_div", dv, vecs[v].exp_div);
            check("vec_res_rem", rm, vecs[v].exp_rem);
        end

        // All requesters held valid: fair rotation at full throughput.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = WIDTH'(8'h11 * (i + 1));
            dmod[i] = ((i + 1) * 'h11) % DIVISOR;
        end
        exp_order = '{0, 1, 2, 3, 0};
        req_valid = '1;
        res_ready = 1'b1;
        gcount = 0;
        rcount = 0;
        for (int c = 0; c < 100 && gcount < 5; c++) begin
            #1;
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) gidx[gcount] = i;
                end
                gcyc[gcount] = c;
                gcount++;
            end
            if (res_valid && rcount < gcount) begin
                check("rr_res_id", res_id, gidx[rcount]);
                check("rr_res_rem", res_rem, dmod[gidx[rcount]]);
                rcount++;
            end
            @(negedge clk);
        end
        check("rr_grant_count", gcount, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < gcount) check("rr_grant_order", gidx[i], exp_order[i]);
            if (i > 0 && i < gcount) check("rr_grant_spacing", gcyc[i] - gcyc[i-1], WIDTH + 2);
        end
        check("rr_result_count", rcount, 4);

        // Result stalled in DONE with another request pending.
        do_reset();
        @(negedge clk);
        req_data[1*WIDTH +: WIDTH] = 8'h11;
        req_data[2*WIDTH +: WIDTH] = 8'h07;
        req_valid = 4'b0110;
        res_ready = 1'b0;
        #1 check("bp_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b0100;
        w = 0;
        #1;
        while (!res_valid && w < 40) begin
            @(negedge clk);
            w++;
            #1;
        end
        check("bp_valid_seen", res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_id", res_id, 1);
            check("bp_hold_rem", res_rem, 2);
            check("bp_hold_div", res_div, 0);
            check("bp_no_grant", req_ready, 0);
            @(negedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("bp_next_grant", req_ready, 4'b0100);
        check("bp_valid_dropped", res_valid, 0);

        // Reset while the granted word is shifting.
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_div", res_div, 0);
        check("rst_res_rem", res_rem, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (res_valid) seen++;
        end
        check("rst_no_result", seen, 0);
        @(negedge clk);
        req_data[1*WIDTH +: WIDTH] = 8'h03;
        req_data[3*WIDTH +: WIDTH] = 8'h09;
        req_valid = 4'b1010;
        #1 check("rst_rr_ptr_zero", req_ready, 4'b0010);

        // Random traffic with backpressure.
        do_reset();
        random_phase(1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_div_arbiter.md
# serial_div_arbiter

Shares one MSB-first serial divisibility checker (mod-DIVISOR residue tracker) among NREQ parallel-word requesters. Arbitrates round-robin, serializes the granted word one bit per clock into the residue core, then returns quotient-free results (divisible flag, remainder) tagged with the requester ID over a valid/ready result port. Sits between word-producing FSM blocks and the serial residue datapath, so a single checker serves every client.

## Interface
- NREQ, 4: number of requesters, ≥2.
- WIDTH, 8: data word width, ≥2.
- DIVISOR, 5: modulus, ≥2; RW = $clog2(DIVISOR) (3 for 5).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant/accept strobe.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_id  out  $clog2(NREQ)  requester index of result.
- res_div  out  1  1 when word mod DIVISOR == 0.
- res_rem  out  RW  word mod DIVISOR.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if any req_valid, grant lowest index at or after rr_ptr (wrapping); req_ready[g]=1 combinationally that cycle only; load shift register with word, clear residue to 0, bit counter = WIDTH-1, latch id = g, rr_ptr <= g+1 mod NREQ; -> SHIFT. No valid -> stay, req_ready all 0.
- SHIFT: each cycle feed shift register MSB to core: rem <= (2*rem + bit) mod DIVISOR, computed as one conditional subtract on an RW+1-bit intermediate (value < 2*DIVISOR); shift left; decrement counter. Counter == 0 on this cycle -> DONE.
- DONE: res_valid=1; res_id, res_div (rem==0), res_rem registered and held stable until res_valid&&res_ready, then -> IDLE. No new grant in DONE or SHIFT; req_ready all 0.
- Requester must hold req_valid/req_data until its req_ready; a requester dropping valid before grant is simply skipped.
- Word 0 yields res_div=1, res_rem=0.
- Reset (rst_n=0 on a clock edge) in any state: abort in-flight word, no result emitted, state IDLE, rr_ptr=0, residue 0.

## Timing
- Reset values: req_ready=0, res_valid=0, res_id=0, res_div=0, res_rem=0.
- Accept on edge t (req_ready high in cycle before edge t); WIDTH bits consumed on edges t+1..t+WIDTH; res_valid high starting cycle after edge t+WIDTH (WIDTH+1 cycles after accept).
- Result accepted on edge u -> IDLE from u; earliest next accept edge u+1. Max throughput one word per WIDTH+2 cycles.
- res_* outputs change only on entry to DONE or reset.

## Structure
- Package serial_div_pkg: state typedef (IDLE/SHIFT/DONE), function for RW, default parameter constants.
- Sub-module serial_mod_core: inputs clk, rst_n, clr, en, bit_in; output rem[RW-1:0]; parameter DIVISOR. Holds residue register and conditional-subtract update. Arbiter, shift register, counter and result registers stay in top.

## Test plan
- req0 only, data 8'h0A -> req_ready=4'b0001 one cycle, res_valid 9 cycles later, res_id=0, res_div=1, res_rem=0.
- req2 data 8'h07 -> res_id=2, res_div=0, res_rem=2; 8'hFF -> res_div=1, rem 0; 8'h00 -> res_div=1, rem 0; 8'hFE -> rem 4.
- All four req_valid held high, res_ready=1 -> grant order 0,1,2,3,0, one grant every 10 cycles, results match software mod 5.
- res_ready low 5 cycles in DONE -> res_valid, res_id, res_rem stable; req_ready stays 0 despite pending requests.
- rst_n low mid-SHIFT -> next cycle all outputs 0, no result; then req3 and req1 valid -> req1 granted first (rr_ptr=0).
- Random words, random res_ready backpressure, 1000 transactions -> every result matches model, no lost or duplicated grant.
